// File: rtl/a_skew_feeder.sv
// Skews row vectors of A into a systolic array: lane i delays element i by i cycles.
// A small FSM tracks streaming, drains the skew after the last vector, then pulses done.
module a_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [N*DATA_WIDTH-1:0]   in_data,
    output logic [N*DATA_WIDTH-1:0]   out_A,
    output logic [N-1:0]              out_valid,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          accept;

    assign in_ready = (state_q != S_DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        // A single lane has no skew to drain, so the last element is already out.
                        if (N == 1) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                            cnt_d   = CNT_LOAD;
                        end
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] data_q [0:gi];
            logic [gi:0]           vld_q;

            // Heads load zero with valid low on non-accept edges so the skew of older vectors is kept.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s <= gi; s++) begin
                        data_q[s] <= '0;
                    end
                    vld_q <= '0;
                end else begin
                    data_q[0] <= accept ? in_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                    vld_q[0]  <= accept;
                    for (int s = 1; s <= gi; s++) begin
                        data_q[s] <= data_q[s-1];
                        vld_q[s]  <= vld_q[s-1];
                    end
                end
            end

            assign out_A[gi*DATA_WIDTH +: DATA_WIDTH] = vld_q[gi] ? data_q[gi] : '0;
            assign out_valid[gi] = vld_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_a_skew_feeder.sv
// Directed and random stimulus for a_skew_feeder against a history-based reference model.
module tb_a_skew_feeder;

    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int MAXC = 2000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_last = 1'b0;
    logic [N*DW-1:0] in_data = '0;
    logic [N*DW-1:0] out_A;
    logic [N-1:0]    out_valid;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    // Reference model: which edges accepted a vector and what it was.
    logic            hv [0:MAXC];
    logic [N*DW-1:0] hd [0:MAXC];
    int              k = 0;
    int              last_edge = -100;
    logic            open_q = 1'b0;

    a_skew_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
        .out_A(out_A), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        return !(k >= last_edge && k <= last_edge + N - 2);
    endfunction

    task automatic check_all();
        logic [N*DW-1:0] ea;
        logic [N-1:0]    ev;
        ea = '0;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            if (k - i >= 0 && hv[k-i]) begin
                ev[i] = 1'b1;
                ea[i*DW +: DW] = hd[k-i][i*DW +: DW];
            end
        end
        chk("out_A", 64'(out_A), 64'(ea));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        chk("busy", 64'(busy), 64'(open_q || !model_ready()));
        chk("done", 64'(done), 64'(k == last_edge + N - 1));
        $display("k=%0d v=%b l=%b d=%h | out_A=%h out_valid=%b rdy=%b busy=%b done=%b",
                 k, in_valid, in_last, in_data, out_A, out_valid, in_ready, busy, done);
    endtask

    task automatic step(input logic v, input logic last, input logic [N*DW-1:0] d);
        logic acc;
        in_valid = v;
        in_last  = last;
        in_data  = d;
        acc = v && model_ready();
        @(posedge clk);
        k++;
        hv[k] = acc;
        hd[k] = d;
        if (acc) begin
            if (last) begin
                last_edge = k;
                open_q    = 1'b0;
            end else begin
                open_q = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_A", 64'(out_A), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i <= MAXC; i++) begin
            hv[i] = 1'b0;
            hd[i] = '0;
        end
        last_edge = -100;
        open_q    = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs();

        // Single vector with last: skew then done, ready low while draining.
        step(1'b1, 1'b1, 32'h04030201);
        idle_steps(4);

        // Back-to-back vectors.
        step(1'b1, 1'b0, 32'h01010101);
        step(1'b1, 1'b0, 32'h02020202);
        step(1'b1, 1'b1, 32'h03030303);
        idle_steps(4);

        // Two-cycle gap in STREAM.
        step(1'b1, 1'b0, 32'h14131211);
        idle_steps(2);
        step(1'b1, 1'b1, 32'h24232221);
        idle_steps(4);

        // Signed extremes {-128,127,-1,0}.
        step(1'b1, 1'b1, 32'h00FF7F80);
        idle_steps(4);

        // Reset pulsed between edges while draining.
        step(1'b1, 1'b0, 32'h35343332);
        step(1'b1, 1'b1, 32'h45444342);
        step(1'b0, 1'b0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        model_reset();
        idle_steps(4);

        // New vector offered in the done cycle, plus an ignored offer during drain.
        step(1'b1, 1'b1, 32'h55545352);
        step(1'b1, 1'b0, 32'hDEADBEEF);
        idle_steps(2);
        step(1'b1, 1'b0, 32'h65646362);
        chk("stream_after_done", 64'(busy), 64'd1);
        step(1'b1, 1'b1, 32'h75747372);
        idle_steps(4);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), $urandom);
        end
        idle_steps(N + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
